// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  // Controller states; FETCH is the reset state and must stay at encoding 0.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // Supported opcodes (instruction bits [31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU_op encodings understood by the downstream ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Raw per-state control vector, before handshake qualification and gating.
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_out_decode.sv
// Moore output decoder: maps the controller state onto the raw control vector.
module mips_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Everything defaults to 0; each state raises only what it needs.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = 2'b01;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: state register, next-state
// logic, memory-ready qualification, PC enable and reset gating of outputs.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       mem_write,
  output logic       IR_write,
  output logic       PC_en,
  output logic [1:0] PC_src,
  output logic       ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic [1:0] ALU_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t state_reg, state_next;
  // Low from reset until the first clock edge after release; silences all
  // outputs so nothing fires in the gap between reset release and the edge.
  logic   active_reg;
  logic   mem_rdy;
  logic   in_fetch;
  ctrl_t  ctrl;

  assign mem_rdy  = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign in_fetch = (state_reg == S_FETCH);

  mips_ctrl_out_decode u_out_decode (
    .state (state_reg),
    .ctrl  (ctrl)
  );

  // State register with asynchronous abort back to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_FETCH;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= 1'b1;
    end
  end

  // Next-state logic; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    state_next = S_FETCH;
    if (active_reg) begin
      case (state_reg)
        S_FETCH:   state_next = mem_rdy ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_RTYPE:     state_next = S_EXECUTE;
            OP_BEQ:       state_next = S_BRANCH;
            OP_ADDI:      state_next = S_ADDIEX;
            OP_J:         state_next = S_JUMP;
            default:      state_next = S_FETCH;
          endcase
        end
        S_MEMADR:  state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state_next = mem_rdy ? S_MEMWB : S_MEMRD;
        S_MEMWB:   state_next = S_FETCH;
        S_MEMWR:   state_next = mem_rdy ? S_FETCH : S_MEMWR;
        S_EXECUTE: state_next = S_ALUWB;
        S_ALUWB:   state_next = S_FETCH;
        S_BRANCH:  state_next = S_FETCH;
        S_ADDIEX:  state_next = S_ADDIWB;
        S_ADDIWB:  state_next = S_FETCH;
        S_JUMP:    state_next = S_FETCH;
        default:   state_next = S_FETCH;
      endcase
    end
  end

  // Output stage: FETCH loads wait for mem_ready, everything gated by active.
  always_comb begin
    IorD       = active_reg & ctrl.iord;
    mem_write  = active_reg & ctrl.mem_write;
    IR_write   = active_reg & ctrl.ir_write & mem_rdy;
    PC_en      = active_reg & ((ctrl.pc_write & (~in_fetch | mem_rdy)) |
                               (ctrl.branch & zero));
    PC_src     = active_reg ? ctrl.pc_src : 2'b00;
    ALU_src_A  = active_reg & ctrl.alu_src_a;
    ALU_src_B  = active_reg ? ctrl.alu_src_b : 2'b00;
    ALU_op     = active_reg ? ctrl.alu_op : 2'b00;
    reg_write  = active_reg & ctrl.reg_write;
    reg_dst    = active_reg & ctrl.reg_dst;
    mem_to_reg = active_reg & ctrl.mem_to_reg;
    illegal_op = active_reg & (state_reg == S_DECODE) & ~is_legal_op(opcode);
    state_o    = state_reg;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS controller. Expected per-cycle output
// vectors are queued when an instruction is scheduled and compared as the
// controller steps through it.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       IorD, mem_write, IR_write, PC_en, ALU_src_A;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] PC_src, ALU_src_B, ALU_op;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  int mw_cnt, rw_cnt, ill_cnt;

  typedef struct {
    logic        mr;
    logic [18:0] exp;
    string       tag;
  } item_t;
  item_t sb[$];

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .mem_write  (mem_write),
    .IR_write   (IR_write),
    .PC_en      (PC_en),
    .PC_src     (PC_src),
    .ALU_src_A  (ALU_src_A),
    .ALU_src_B  (ALU_src_B),
    .ALU_op     (ALU_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {IorD, mem_write, IR_write, PC_en, PC_src, ALU_src_A, ALU_src_B,
                ALU_op, reg_write, reg_dst, mem_to_reg, illegal_op, state_o};

  // Expected output vector for one cycle, straight from the state table.
  function automatic logic [18:0] exp_vec(state_t st, logic mr, logic z, logic [5:0] op);
    logic iord = 0, mw = 0, irw = 0, pcen = 0, a = 0, rw = 0, rd = 0, m2r = 0, ill = 0;
    logic [1:0] pcs = 2'b00, b = 2'b00, aop = 2'b00;
    logic [3:0] s = st;
    case (st)
      S_FETCH:   begin b = 2'b01; irw = mr; pcen = mr; end
      S_DECODE:  begin b = 2'b11; ill = !(op == 6'b100011 || op == 6'b101011 ||
                       op == 6'b000000 || op == 6'b000100 || op == 6'b001000 ||
                       op == 6'b000010); end
      S_MEMADR:  begin a = 1; b = 2'b10; end
      S_MEMRD:   begin iord = 1; end
      S_MEMWB:   begin m2r = 1; rw = 1; end
      S_MEMWR:   begin iord = 1; mw = 1; end
      S_EXECUTE: begin a = 1; aop = 2'b10; end
      S_ALUWB:   begin rd = 1; rw = 1; end
      S_BRANCH:  begin a = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
      S_ADDIEX:  begin a = 1; b = 2'b10; end
      S_ADDIWB:  begin rw = 1; end
      S_JUMP:    begin pcs = 2'b10; pcen = 1; end
      default:   ;
    endcase
    return {iord, mw, irw, pcen, pcs, a, b, aop, rw, rd, m2r, ill, s};
  endfunction

  task automatic push_raw(input logic mr, input logic [18:0] e, input string tag);
    item_t it;
    it.mr = mr; it.exp = e; it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic push(input state_t st, input logic mr, input string tag);
    push_raw(mr, exp_vec(st, mr, zero, opcode), tag);
  endtask

  task automatic check_val(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // Runs queued cycles: drive mem_ready, compare at the falling edge.
  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr;
      @(negedge clk);
      checks++;
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s: observed %05h expected %05h", it.tag, obs, it.exp);
      end
      if (mem_write)  mw_cnt++;
      if (reg_write)  rw_cnt++;
      if (illegal_op) ill_cnt++;
      $display("cycle %s state=%0d obs=%05h", it.tag, state_o, obs);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Held in reset: everything zero even with mem_ready high.
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_raw(1'b1, 19'd0, "reset_hold");
    drain();
    // Release between edges: still silent until the first edge.
    reset_n = 1'b1;
    push_raw(1'b1, 19'd0, "post_release");
    drain();

    // lw, no wait states: 5 cycles.
    opcode = OP_LW; rw_cnt = 0;
    push(S_FETCH, 1, "lw_fetch");   push(S_DECODE, 1, "lw_decode");
    push(S_MEMADR, 1, "lw_memadr"); push(S_MEMRD, 1, "lw_memrd");
    push(S_MEMWB, 1, "lw_memwb");
    drain();
    check_val("lw_reg_write_count", rw_cnt, 1);

    // sw with two wait cycles in MEMWR.
    opcode = OP_SW; mw_cnt = 0;
    push(S_FETCH, 1, "sw_fetch");   push(S_DECODE, 1, "sw_decode");
    push(S_MEMADR, 1, "sw_memadr"); push(S_MEMWR, 0, "sw_memwr0");
    push(S_MEMWR, 0, "sw_memwr1");  push(S_MEMWR, 1, "sw_memwr2");
    drain();
    check_val("sw_mem_write_cycles", mw_cnt, 3);

    // R-type with a fetch wait state.
    opcode = OP_RTYPE; rw_cnt = 0;
    push(S_FETCH, 0, "r_fetch_wait"); push(S_FETCH, 1, "r_fetch");
    push(S_DECODE, 1, "r_decode");    push(S_EXECUTE, 1, "r_execute");
    push(S_ALUWB, 1, "r_aluwb");
    drain();
    check_val("r_reg_write_count", rw_cnt, 1);

    // beq taken and not taken.
    opcode = OP_BEQ; zero = 1'b1;
    push(S_FETCH, 1, "beq1_fetch"); push(S_DECODE, 1, "beq1_decode");
    push(S_BRANCH, 1, "beq1_branch");
    drain();
    zero = 1'b0;
    push(S_FETCH, 1, "beq0_fetch"); push(S_DECODE, 1, "beq0_decode");
    push(S_BRANCH, 1, "beq0_branch");
    drain();

    // addi and j.
    opcode = OP_ADDI;
    push(S_FETCH, 1, "addi_fetch");  push(S_DECODE, 1, "addi_decode");
    push(S_ADDIEX, 1, "addi_ex");    push(S_ADDIWB, 1, "addi_wb");
    drain();
    opcode = OP_J;
    push(S_FETCH, 1, "j_fetch"); push(S_DECODE, 1, "j_decode");
    push(S_JUMP, 1, "j_jump");
    drain();

    // Illegal opcode: one-cycle pulse in DECODE, back to FETCH, no writes.
    opcode = 6'b111111; ill_cnt = 0; rw_cnt = 0; mw_cnt = 0;
    push(S_FETCH, 1, "ill_fetch"); push(S_DECODE, 1, "ill_decode");
    push(S_FETCH, 0, "ill_refetch");
    drain();
    check_val("ill_pulse_count", ill_cnt, 1);
    check_val("ill_no_writes", rw_cnt + mw_cnt, 0);

    // Reset asserted while stalled in MEMWR.
    opcode = OP_SW;
    push(S_FETCH, 1, "rst_fetch");   push(S_DECODE, 1, "rst_decode");
    push(S_MEMADR, 1, "rst_memadr"); push(S_MEMWR, 0, "rst_memwr");
    drain();
    mem_ready = 1'b0;
    #1;
    check_val("rst_memwr_before", mem_write, 1);
    reset_n = 1'b0;
    #1;
    check_val("rst_mem_write_async", mem_write, 0);
    check_val("rst_outputs_zero", int'(obs), 0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check_val("rst_release_zero", int'(obs), 0);
    @(posedge clk);
    #1;
    // First active cycle is a clean FETCH; no stale writeback.
    opcode = OP_LW; rw_cnt = 0;
    push(S_FETCH, 1, "after_rst_fetch"); push(S_DECODE, 1, "after_rst_decode");
    drain();
    check_val("after_rst_no_write", rw_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
